// File: rtl/sram_mem_ctrl_if.sv
// sram_mem_ctrl_if: pipeline-side request bus and external SRAM pins of the data-memory controller.
interface sram_mem_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, addr_err, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits 32-bit loads/stores into two 16-bit SRAM accesses, stalling the pipeline via ready.
// Optional address checking is enabled by defining SRAM_MEM_CTRL_ADDR_CHECK_EN.
module sram_mem_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input logic            clk,
    input logic            rst,
    sram_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic        is_wr_q, is_wr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        req, bad, last, act, hi;
    assign req  = bus.wr_en | bus.rd_en;
    assign last = cnt_q == LAST;
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
    assign bad = (bus.address < BASE_ADDR) || (bus.address[1:0] != 2'b00);
`else
    assign bad = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                is_wr_d = bus.wr_en;
                word_d  = 17'((bus.address - BASE_ADDR) >> 2);
                cnt_d   = '0;
                err_d   = bad;
                state_d = bad ? DONE : LOW;
            end
            LOW: if (last) begin
                if (!is_wr_q) rdata_d[15:0] = bus.sram_dq_in;
                cnt_d   = '0;
                state_d = HIGH;
            end else cnt_d = cnt_q + 4'd1;
            HIGH: if (last) begin
                if (!is_wr_q) rdata_d[31:16] = bus.sram_dq_in;
                cnt_d   = '0;
                state_d = DONE;
            end else cnt_d = cnt_q + 4'd1;
            default: state_d = IDLE;
        endcase
    end
    // Strobes and address are decoded straight from state so nothing is driven outside LOW/HIGH.
    assign act = (state_q == LOW) || (state_q == HIGH);
    assign hi  = state_q == HIGH;
    always_comb begin
        bus.ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
        bus.read_data   = rdata_q;
        bus.addr_err    = (state_q == DONE) && err_q;
        bus.sram_addr   = act ? {word_q, hi} : 18'd0;
        bus.sram_dq_out = (act && is_wr_q) ? (hi ? bus.write_data[31:16] : bus.write_data[15:0]) : 16'd0;
        bus.sram_dq_oe  = act && is_wr_q;
        bus.sram_we_n   = !(act && is_wr_q);
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: randomized self-checking bench with SRAM environment and halfword reference model.
module tb_sram_mem_ctrl;
    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rd = '0;
    logic [15:0] sram [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [15:0] sram1 [0:1023];
    sram_mem_ctrl_if bus ();
    sram_mem_ctrl_if bus1 ();
    sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    always #5 clk = ~clk;
    always @(posedge clk) if (!bus.sram_we_n) sram[bus.sram_addr[9:0]] <= bus.sram_dq_out;
    always @(posedge clk) if (!bus1.sram_we_n) sram1[bus1.sram_addr[9:0]] <= bus1.sram_dq_out;
    assign bus.sram_dq_in  = sram[bus.sram_addr[9:0]];
    assign bus1.sram_dq_in = sram1[bus1.sram_addr[9:0]];
    task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic [16:0] w;
        logic [17:0] ea;
        logic [15:0] ed;
        logic [9:0]  lo, hix;
        int last;
        last = 2 * W + 1;
        w    = 17'((addr - BASE) >> 2);
        lo   = {w[8:0], 1'b0};
        hix  = {w[8:0], 1'b1};
        bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ready !== (k == last)) begin n_fail++; $display("FAIL %s ready k=%0d: got %b exp %b", tag, k, bus.ready, k == last); end
            if (k >= 1 && k <= 2 * W) begin
                ea = {w, k > W};
                ed = (k > W) ? data[31:16] : data[15:0];
                n_tests++;
                if (bus.sram_addr !== ea) begin n_fail++; $display("FAIL %s sram_addr k=%0d: got %h exp %h", tag, k, bus.sram_addr, ea); end
                n_tests++;
                if (bus.sram_we_n !== !wr || bus.sram_dq_oe !== wr) begin n_fail++; $display("FAIL %s strobes k=%0d: got we_n=%b oe=%b exp we_n=%b oe=%b", tag, k, bus.sram_we_n, bus.sram_dq_oe, !wr, wr); end
                if (wr) begin
                    n_tests++;
                    if (bus.sram_dq_out !== ed) begin n_fail++; $display("FAIL %s dq_out k=%0d: got %h exp %h", tag, k, bus.sram_dq_out, ed); end
                end
            end else begin
                n_tests++;
                if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL %s idle strobes k=%0d: got we_n=%b oe=%b exp 1 0", tag, k, bus.sram_we_n, bus.sram_dq_oe); end
            end
            if (k == last) begin
                if (wr) begin
                    ref_mem[lo]  = data[15:0];
                    ref_mem[hix] = data[31:16];
                    n_tests++;
                    if (sram[lo] !== data[15:0] || sram[hix] !== data[31:16]) begin n_fail++; $display("FAIL %s sram content: got %h_%h exp %h", tag, sram[hix], sram[lo], data); end
                end else if (rd) exp_rd = {ref_mem[hix], ref_mem[lo]};
                n_tests++;
                if (bus.read_data !== exp_rd) begin n_fail++; $display("FAIL %s read_data: got %h exp %h", tag, bus.read_data, exp_rd); end
                n_tests++;
                if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL %s addr_err: got %b exp 0", tag, bus.addr_err); end
            end
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset ctrl: got ready=%b we_n=%b oe=%b exp 1 1 0", bus.ready, bus.sram_we_n, bus.sram_dq_oe); end
        n_tests++;
        if (bus.sram_addr !== 18'd0 || bus.sram_dq_out !== 16'd0) begin n_fail++; $display("FAIL reset bus: got addr=%h dq=%h exp 0 0", bus.sram_addr, bus.sram_dq_out); end
        n_tests++;
        if (bus.read_data !== 32'd0 || bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset data: got rd=%h err=%b exp 0 0", bus.read_data, bus.addr_err); end
        @(posedge clk); #1;
    endtask
    task automatic test_write_read();
        run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, "write");
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, "read");
        n_tests++;
        if (exp_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL model readback: got %h exp deadbeef", exp_rd); end
    endtask
    task automatic test_wr_rd_both();
        run_access(1'b1, 1'b1, 32'd1024, 32'h12345678, "wr_rd");
        n_tests++;
        if (sram[0] !== 16'h5678 || sram[1] !== 16'h1234) begin n_fail++; $display("FAIL wr_rd halfwords: got %h %h exp 5678 1234", sram[0], sram[1]); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            bit wr, rd;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            run_access(wr, rd, BASE + 32'(4 * $urandom_range(0, 255)), $urandom, "rand");
        end
    endtask
    task automatic test_back_to_back();
        bit          exp_ready [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        logic [17:0] exp_addr  [8] = '{0, 0, 1, 0, 0, 4, 5, 0};
        logic [31:0] exp_data;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b1; bus1.address = 32'd1024; bus1.write_data = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus1.ready !== exp_ready[k]) begin n_fail++; $display("FAIL b2b ready k=%0d: got %b exp %b", k, bus1.ready, exp_ready[k]); end
            if (k == 1 || k == 2 || k == 5 || k == 6) begin
                n_tests++;
                if (bus1.sram_addr !== exp_addr[k]) begin n_fail++; $display("FAIL b2b sram_addr k=%0d: got %h exp %h", k, bus1.sram_addr, exp_addr[k]); end
            end
            if (k == 3 || k == 7) begin
                exp_data = (k == 3) ? {sram1[1], sram1[0]} : {sram1[5], sram1[4]};
                n_tests++;
                if (bus1.read_data !== exp_data) begin n_fail++; $display("FAIL b2b read_data k=%0d: got %h exp %h", k, bus1.read_data, exp_data); end
            end
            @(posedge clk); #1;
            if (k == 3) bus1.address = 32'd1032;
        end
        bus1.rd_en = 1'b0;
    endtask
    task automatic test_reset_mid();
        bus.wr_en = 1'b1; bus.rd_en = 1'b0; bus.address = BASE + 32'd1600; bus.write_data = $urandom;
        repeat (W + 1) @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (bus.sram_addr !== 18'd801 || bus.sram_we_n !== 1'b0) begin n_fail++; $display("FAIL mid high phase: got addr=%h we_n=%b exp 321 0", bus.sram_addr, bus.sram_we_n); end
        rst = 1'b1; bus.wr_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        n_tests++;
        if (bus.ready !== 1'b1 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL mid reset ctrl: got ready=%b we_n=%b oe=%b exp 1 1 0", bus.ready, bus.sram_we_n, bus.sram_dq_oe); end
        n_tests++;
        if (bus.read_data !== 32'd0 || bus.sram_addr !== 18'd0) begin n_fail++; $display("FAIL mid reset data: got rd=%h addr=%h exp 0 0", bus.read_data, bus.sram_addr); end
        @(posedge clk); #1;
    endtask
    task automatic test_addr_err();
`ifdef SRAM_MEM_CTRL_ADDR_CHECK_EN
        bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.address = 32'd1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ready !== (k != 0) || bus.addr_err !== (k == 1)) begin n_fail++; $display("FAIL oob k=%0d: got ready=%b err=%b exp %b %b", k, bus.ready, bus.addr_err, k != 0, k == 1); end
            n_tests++;
            if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0 || bus.read_data !== exp_rd) begin n_fail++; $display("FAIL oob side effects k=%0d: got we_n=%b oe=%b rd=%h exp 1 0 %h", k, bus.sram_we_n, bus.sram_dq_oe, bus.read_data, exp_rd); end
            @(posedge clk); #1;
            if (k == 1) bus.rd_en = 1'b0;
        end
`else
        run_access(1'b0, 1'b1, 32'd1000, 32'h0, "oob");
`endif
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 16'($urandom);
            ref_mem[i] = sram[i];
            sram1[i]   = 16'($urandom);
        end
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.address = '0; bus1.write_data = '0;
        test_reset();
        test_write_read();
        test_wr_rd_both();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_addr_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
